serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor, the inverse operation of the team's 4-bit ripple adder. Computes D = A - B - Bin and a borrow-out, one bit per cycle, LSB first, through a single borrow flip-flop. Operands and results use valid/ready handshakes, so the block can sit in a datapath between a producer and a consumer that apply backpressure.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing D = A - B - Bin
// and a borrow-out, one bit per clock, LSB first, through a single borrow flop.
// Operands arrive on a valid/ready handshake and results leave on another, so
// both the producer and the consumer may stall the block.
//
// Optional build macro: SERIAL_SUB_OVF_EN
//   When defined, adds output V, the signed two's-complement overflow of the
//   subtraction (borrow into MSB XOR borrow out of MSB), latched with Bout.
//   When undefined, port V does not exist and behaviour is otherwise identical.

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_a;
  logic             bit_b;
  logic             bit_d;
  logic             br_next;

  // One-bit full-subtractor slice on the current LSBs and the stored borrow.
  always_comb begin
    bit_a   = a_sh[0];
    bit_b   = b_sh[0];
    bit_d   = bit_a ^ bit_b ^ br;
    br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  end

  // Control FSM and datapath; outputs are registered so D/Bout hold steady
  // through DONE and keep the last result after returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      d_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      D         <= '0;
      Bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      V         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= A;
            b_sh     <= B;
            br       <= Bin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          d_sh <= {bit_d, d_sh[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            D         <= {bit_d, d_sh[WIDTH-1:1]};
            Bout      <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            V         <= br ^ br_next;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed-vector bench for serial_subtractor (WIDTH=4)
// with hand-computed differences, borrows, latency, backpressure, back-to-back
// throughput and mid-operation reset.

module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             V;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .V         (V)
`endif
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure result spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand bundle for a single handshake edge; caller ensures IDLE.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    A        = a;
    B        = b;
    Bin      = bin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, checking in_ready stays low; n counts edges already elapsed.
  task automatic waitValid(inout int n);
    while (!out_valid && n < 50) begin
      checkOutput("in_ready_low_run", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid_drop", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input logic [WIDTH-1:0] expD, input logic expBout,
                       input logic expV);
    int n;
    applyStimulus(a, b, bin);
    n = 1;
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    waitValid(n);
    checkOutput({tag, "_latency"}, n, WIDTH + 1);
    checkOutput({tag, "_D"}, {28'd0, D}, {28'd0, expD});
    checkOutput({tag, "_Bout"}, {31'd0, Bout}, {31'd0, expBout});
    checkOutput({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, "_V"}, {31'd0, V}, {31'd0, expV});
`else
    if (expV) begin
    end
`endif
    releaseResult();
  endtask

  logic [WIDTH-1:0] qa   [3] = '{4'd5, 4'd2, 4'd12};
  logic [WIDTH-1:0] qb   [3] = '{4'd2, 4'd5, 4'd12};
  logic             qbin [3] = '{1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] qd   [3] = '{4'd3, 4'd13, 4'd15};
  logic             qbo  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int k;
    int guard;
    int stamp [3];
    int sawValid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_D", {28'd0, D}, 32'd0);
    checkOutput("rst_Bout", {31'd0, Bout}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Directed arithmetic vectors, including boundary cases.
    runOp("zero",     4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    runOp("4m1",      4'b0100, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);
    runOp("3m4",      4'b0011, 4'b0100, 1'b0, 4'b1111, 1'b1, 1'b0);
    runOp("14m8m1",   4'b1110, 4'b1000, 1'b1, 4'b0101, 1'b0, 1'b0);
    runOp("0m0m1",    4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    runOp("ones_m0",  4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    runOp("eq",       4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0);
    runOp("ovf",      4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);

    // Backpressure: result must hold for 7 cycles and no operand is taken.
    applyStimulus(4'd9, 4'd3, 1'b0);
    k = 1;
    waitValid(k);
    A        = 4'd1;
    B        = 4'd1;
    Bin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_D", {28'd0, D}, 32'd6);
      checkOutput("bp_Bout", {31'd0, Bout}, 32'd0);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("idle_keeps_D", {28'd0, D}, 32'd6);

    // Back-to-back: three queued operand sets, consumer always ready.
    out_ready = 1'b1;
    k = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          A        = qa[i];
          B        = qb[i];
          Bin      = qbin[i];
          in_valid = 1'b1;
          guard    = 0;
          while (!in_ready && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
          end
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60 && k < 3; c++) begin
          @(posedge clk);
          #1;
          if (out_valid) begin
            checkOutput("b2b_D", {28'd0, D}, {28'd0, qd[k]});
            checkOutput("b2b_Bout", {31'd0, Bout}, {31'd0, qbo[k]});
            stamp[k] = cyc;
            k++;
          end
        end
      end
    join
    checkOutput("b2b_count", k, 3);
    if (k == 3) begin
      checkOutput("b2b_gap01", stamp[1] - stamp[0], WIDTH + 2);
      checkOutput("b2b_gap12", stamp[2] - stamp[1], WIDTH + 2);
    end
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle aborts the operation.
    applyStimulus(4'b1010, 4'b0101, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_D", {28'd0, D}, 32'd0);
    checkOutput("abort_Bout", {31'd0, Bout}, 32'd0);
    sawValid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1;
    end
    checkOutput("abort_no_result", sawValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
